delay_sequencer: RTL and testbench
==================================

Name: delay_sequencer

Overview:
- Initiator side of the 2 kHz timing-counter handshake.
- Accepts delay requests from the global BlackJack FSM (card reveal, dealer pause, result display) and runs the counter for N consecutive two-second periods.
- Per period: strobes counter clear, waits for clear acknowledge, enables counting, waits for the two-second flag.
- Reports completion, abort, or a clear-acknowledge timeout back to the global FSM.

Parameters:
PW, 4, width of period request and remaining-period count
TO_CYCLES, 8, max cycles in WAIT_OK waiting for i_RstOK before error (≥2)

Ports:
clk_2K  input  1  2 kHz system clock
i_ResetN  input  1  reset, synchronous, active-low, sampled on rising clk_2K
i_Start  input  1  delay request; sampled only in IDLE
i_Periods  input  PW  number of two-second periods; sampled with i_Start
i_Abort  input  1  cancel current delay
i_TwoSec  input  1  counter two-second flag
i_RstOK  input  1  counter clear acknowledge (one-cycle pulse)
o_ActCounter  output  1  counter enable
o_RstCounter  output  1  counter clear strobe
o_Busy  output  1  high in any state except IDLE
o_Done  output  1  one-cycle pulse, delay completed
o_Error  output  1  one-cycle pulse, clear acknowledge timed out
o_Remaining  output  PW  periods still to run

Behaviour:
- All outputs registered, Moore-decoded from state. Priority per edge: reset > abort > all else.
- Reset (i_ResetN=0 at edge): state IDLE, timeout timer 0, all outputs 0 from the next cycle. Applies mid-operation.
- States: IDLE, CLEAR, WAIT_OK, RUN, DONE, ERR.
- IDLE: all outputs 0, o_Remaining holds its last value.
  - i_Start=1, i_Periods≥1: latch o_Remaining=i_Periods, go CLEAR.
  - i_Start=1, i_Periods=0: go DONE. No counter strobes.
- CLEAR: exactly one cycle with o_RstCounter=1, o_ActCounter=0. Timer cleared. Go WAIT_OK.
- WAIT_OK: o_RstCounter=0, o_ActCounter=0.
  - i_RstOK=1 at edge: go RUN.
  - Otherwise timer increments; if timer==TO_CYCLES-1 with no i_RstOK: go ERR.
  - WAIT_OK therefore lasts at most TO_CYCLES cycles.
- RUN: o_ActCounter=1.
  - i_TwoSec=1 at edge: o_Remaining decrements. If o_Remaining was 1, go DONE; else go CLEAR for the next period.
  - i_TwoSec is ignored outside RUN.
- DONE: o_Done=1, o_ActCounter=0, o_Remaining=0, one cycle, then IDLE.
- ERR: o_Error=1 one cycle, o_Remaining holds, then IDLE.
- i_Abort=1 in CLEAR/WAIT_OK/RUN: next state IDLE, o_Remaining=0, no o_Done/o_Error. Abort together with i_TwoSec or i_RstOK also wins. Abort in DONE/ERR has no effect; the pulse completes.
- i_Start outside IDLE is ignored; no queuing. A start in the first IDLE cycle after DONE/ERR is accepted.
- Latency, start at edge E:
  - CLEAR at E+1.
  - WAIT_OK at E+2.
  - Counter returns i_RstOK during E+2, so RUN at E+3 at the earliest.
  - DONE the cycle after the final i_TwoSec edge.
- o_Remaining decrement never wraps: DONE is taken from value 1, and 0 is only loaded via the IDLE→DONE path.
- o_RstCounter and o_ActCounter are never high in the same cycle.

Test Plan:
1. Reset: i_ResetN=0 for 2 edges while in RUN → next cycle all outputs 0, state IDLE; release, i_Start=1, i_Periods=1 → o_RstCounter=1 exactly one cycle later.
2. Two periods against a counter model (WIDTH=4): i_Start, i_Periods=2 → two CLEAR/WAIT_OK/RUN cycles, o_Remaining 2→1→0, exactly two o_RstCounter pulses, one o_Done pulse the cycle after the second i_TwoSec.
3. Zero periods: i_Start, i_Periods=0 → o_Done=1 on the next cycle; o_RstCounter and o_ActCounter stay 0 throughout.
4. Timeout, TO_CYCLES=8: counter model never returns i_RstOK → o_Error pulses one cycle after 8 WAIT_OK cycles, o_Busy falls next cycle, o_Done stays 0. Repeat with i_RstOK in WAIT_OK cycle 8 → RUN, no error.
5. Abort: i_Periods=3, assert i_Abort in the same cycle as the first i_TwoSec → IDLE, o_Remaining=0, no o_Done. Then i_Start immediately → accepted.
6. Start while busy: pulse i_Start with i_Periods=5 during RUN of a 1-period delay → ignored, o_Remaining unchanged, single o_Done.

Source files
------------

// File: rtl/delay_sequencer.sv
// Initiator side of the 2 kHz timing-counter handshake.
// Runs the counter for N two-second periods, reporting done/abort/timeout.
module delay_sequencer #(
    parameter int PW        = 4,
    parameter int TO_CYCLES = 8
) (
    input  logic          clk_2K,
    input  logic          i_ResetN,
    input  logic          i_Start,
    input  logic [PW-1:0] i_Periods,
    input  logic          i_Abort,
    input  logic          i_TwoSec,
    input  logic          i_RstOK,
    output logic          o_ActCounter,
    output logic          o_RstCounter,
    output logic          o_Busy,
    output logic          o_Done,
    output logic          o_Error,
    output logic [PW-1:0] o_Remaining
);

    localparam int            TW      = $clog2(TO_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_OK,
        S_RUN,
        S_DONE,
        S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] rem_q, rem_d;
    logic          act_q, act_d;
    logic          rst_q, rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Next state, timer and period count; abort overrides the active states.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    if (i_Periods != '0) begin
                        rem_d   = i_Periods;
                        state_d = S_CLEAR;
                    end else begin
                        rem_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                timer_d = '0;
                state_d = S_WAIT_OK;
            end
            S_WAIT_OK: begin
                if (i_RstOK) begin
                    state_d = S_RUN;
                end else if (timer_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RUN: begin
                if (i_TwoSec) begin
                    rem_d   = rem_q - PW'(1);
                    state_d = (rem_q == PW'(1)) ? S_DONE : S_CLEAR;
                end
            end
            S_DONE: begin
                rem_d   = '0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (i_Abort && (state_q inside {S_CLEAR, S_WAIT_OK, S_RUN})) begin
            state_d = S_IDLE;
            rem_d   = '0;
        end
    end

    // Moore output decode from the upcoming state, so outputs can be registered.
    always_comb begin
        act_d  = (state_d == S_RUN);
        rst_d  = (state_d == S_CLEAR);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    // State, timer, count and output registers with synchronous reset.
    always_ff @(posedge clk_2K) begin
        if (!i_ResetN) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            rem_q   <= '0;
            act_q   <= 1'b0;
            rst_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            act_q   <= act_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_ActCounter = act_q;
    assign o_RstCounter = rst_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;
    assign o_Error      = err_q;
    assign o_Remaining  = rem_q;

endmodule

// File: tb/tb_delay_sequencer.sv
// Bench for delay_sequencer: scenario timelines built from the
// handshake rules, replayed cycle by cycle against the outputs.
module tb_delay_sequencer;

    logic       clk_2K = 1'b0;
    logic       i_ResetN;
    logic       i_Start;
    logic [3:0] i_Periods;
    logic       i_Abort;
    logic       i_TwoSec;
    logic       i_RstOK;
    logic       o_ActCounter;
    logic       o_RstCounter;
    logic       o_Busy;
    logic       o_Done;
    logic       o_Error;
    logic [3:0] o_Remaining;

    int checks = 0;
    int errors = 0;

    delay_sequencer #(.PW(4), .TO_CYCLES(8)) dut (
        .clk_2K      (clk_2K),
        .i_ResetN    (i_ResetN),
        .i_Start     (i_Start),
        .i_Periods   (i_Periods),
        .i_Abort     (i_Abort),
        .i_TwoSec    (i_TwoSec),
        .i_RstOK     (i_RstOK),
        .o_ActCounter(o_ActCounter),
        .o_RstCounter(o_RstCounter),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_Error     (o_Error),
        .o_Remaining (o_Remaining)
    );

    always #5 clk_2K = ~clk_2K;

    typedef struct packed {
        logic       rstn;
        logic       start;
        logic [3:0] per;
        logic       abort;
        logic       twosec;
        logic       rstok;
    } stim_t;

    typedef struct packed {
        logic       act;
        logic       rst;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] rem;
    } obs_t;

    stim_t sq[$];
    obs_t  eq[$];
    int    m_rem = 0;
    int    dly[8];
    int    run_len[8];

    function automatic obs_t mk(logic a, logic r, logic b, logic d,
                                logic e, int rem);
        obs_t o;
        o.act = a; o.rst = r; o.busy = b; o.done = d; o.err = e;
        o.rem = rem[3:0];
        return o;
    endfunction

    function automatic obs_t o_idle(int rem);  return mk(0,0,0,0,0,rem); endfunction
    function automatic obs_t o_clear(int rem); return mk(0,1,1,0,0,rem); endfunction
    function automatic obs_t o_wait(int rem);  return mk(0,0,1,0,0,rem); endfunction
    function automatic obs_t o_run(int rem);   return mk(1,0,1,0,0,rem); endfunction
    function automatic obs_t o_done();         return mk(0,0,1,1,0,0);   endfunction
    function automatic obs_t o_err(int rem);   return mk(0,0,1,0,1,rem); endfunction

    function automatic stim_t idle_s();
        stim_t s;
        s = '0;
        s.rstn = 1'b1;
        return s;
    endfunction

    // Inputs that must not change the outcome outside IDLE/RUN.
    function automatic stim_t quiet(int mode);
        stim_t s;
        s = idle_s();
        if (mode == 1) begin
            s.start  = 1'($urandom_range(0, 1));
            s.per    = 4'($urandom_range(0, 15));
            s.twosec = 1'($urandom_range(0, 1));
        end
        return s;
    endfunction

    // Inputs that must not change the outcome while counting.
    function automatic stim_t quiet_run(int mode);
        stim_t s;
        s = idle_s();
        if (mode == 1) begin
            s.start = 1'($urandom_range(0, 1));
            s.per   = 4'($urandom_range(0, 15));
            s.rstok = 1'($urandom_range(0, 1));
        end else if (mode == 2) begin
            s.start = 1'b1;
            s.per   = 4'd5;
        end
        return s;
    endfunction

    function automatic void push(stim_t s, obs_t e);
        sq.push_back(s);
        eq.push_back(e);
    endfunction

    // Timeline of one delay request: dly[k]=0 means the clear is never
    // acknowledged, else the acknowledge comes in WAIT_OK cycle dly[k];
    // run_len[k] is the RUN cycle carrying the two-second flag.
    // ab_mode 1: abort with that flag, 2: abort with the acknowledge.
    function automatic void gen_delay(int n, int ab_k, int ab_mode, int noise);
        stim_t s;
        s = idle_s();
        s.start = 1'b1;
        s.per = n[3:0];
        if (n == 0) begin
            push(s, o_done());
            m_rem = 0;
            push(quiet(noise), o_idle(0));
            return;
        end
        push(s, o_clear(n));
        m_rem = n;
        for (int k = 0; k < n; k++) begin
            push(quiet(noise), o_wait(m_rem));
            if (ab_k == k && ab_mode == 2) begin
                s = idle_s();
                s.rstok = 1'b1;
                s.abort = 1'b1;
                push(s, o_idle(0));
                m_rem = 0;
                return;
            end
            if (dly[k] == 0) begin
                repeat (7) push(quiet(noise), o_wait(m_rem));
                push(quiet(noise), o_err(m_rem));
                push(quiet(noise), o_idle(m_rem));
                return;
            end
            repeat (dly[k] - 1) push(quiet(noise), o_wait(m_rem));
            s = idle_s();
            s.rstok = 1'b1;
            push(s, o_run(m_rem));
            repeat (run_len[k] - 1) push(quiet_run(noise), o_run(m_rem));
            s = idle_s();
            s.twosec = 1'b1;
            if (ab_k == k && ab_mode == 1) begin
                s.abort = 1'b1;
                push(s, o_idle(0));
                m_rem = 0;
                return;
            end
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                push(s, o_done());
                push(quiet(noise), o_idle(0));
                return;
            end
            push(s, o_clear(m_rem));
        end
    endfunction

    task automatic drive_step(input stim_t s);
        i_ResetN  = s.rstn;
        i_Start   = s.start;
        i_Periods = s.per;
        i_Abort   = s.abort;
        i_TwoSec  = s.twosec;
        i_RstOK   = s.rstok;
        @(posedge clk_2K);
        #1;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.act = o_ActCounter; o.rst = o_RstCounter; o.busy = o_Busy;
        o.done = o_Done; o.err = o_Error; o.rem = o_Remaining;
        return o;
    endfunction

    task automatic test_reset();
        stim_t s;
        obs_t  e, got;
        int    i = 0;
        s = idle_s();
        s.rstn = 1'b0;
        push(s, o_idle(0));
        push(s, o_idle(0));
        m_rem = 0;
        s = idle_s(); s.start = 1'b1; s.per = 4'd3;
        push(s, o_clear(3));
        push(idle_s(), o_wait(3));
        s = idle_s(); s.rstok = 1'b1;
        push(s, o_run(3));
        push(idle_s(), o_run(3));
        s = idle_s(); s.rstn = 1'b0; s.twosec = 1'b1;
        push(s, o_idle(0));
        push(s, o_idle(0));
        s = idle_s(); s.start = 1'b1; s.per = 4'd1;
        push(s, o_clear(1));
        s = idle_s(); s.abort = 1'b1;
        push(s, o_idle(0));
        m_rem = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            drive_step(s);
            got = sample();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset step %0d act,rst,busy,done,err,rem got %b exp %b",
                         i, got, e);
            end
            i++;
        end
    endtask

    task automatic test_two_periods();
        stim_t s;
        obs_t  e, got;
        int    i = 0;
        dly[0] = 1; dly[1] = 3;
        run_len[0] = 2; run_len[1] = 4;
        gen_delay(2, -1, 0, 0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            drive_step(s);
            got = sample();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL two_periods step %0d got %b exp %b", i, got, e);
            end
            i++;
        end
    endtask

    task automatic test_zero();
        stim_t s;
        obs_t  e, got;
        int    i = 0;
        gen_delay(0, -1, 0, 0);
        push(idle_s(), o_idle(0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            drive_step(s);
            got = sample();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL zero_periods step %0d got %b exp %b", i, got, e);
            end
            i++;
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        obs_t  e, got;
        int    i = 0;
        dly[0] = 0;
        gen_delay(1, -1, 0, 0);
        dly[0] = 8; run_len[0] = 1;
        gen_delay(1, -1, 0, 0);
        dly[0] = 1; dly[1] = 0;
        run_len[0] = 2;
        gen_delay(4, -1, 0, 1);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            drive_step(s);
            got = sample();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL timeout step %0d got %b exp %b", i, got, e);
            end
            i++;
        end
    endtask

    task automatic test_abort();
        stim_t s;
        obs_t  e, got;
        int    i = 0;
        for (int k = 0; k < 3; k++) begin
            dly[k] = 1; run_len[k] = 2;
        end
        gen_delay(3, 0, 1, 0);
        gen_delay(2, -1, 0, 0);
        gen_delay(3, 1, 2, 0);
        gen_delay(1, -1, 0, 0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            drive_step(s);
            got = sample();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL abort step %0d got %b exp %b", i, got, e);
            end
            i++;
        end
    endtask

    task automatic test_start_busy();
        stim_t s;
        obs_t  e, got;
        int    i = 0;
        dly[0] = 1; run_len[0] = 3;
        gen_delay(1, -1, 0, 2);
        push(idle_s(), o_idle(0));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            drive_step(s);
            got = sample();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL start_busy step %0d got %b exp %b", i, got, e);
            end
            i++;
        end
    endtask

    task automatic test_random();
        stim_t s;
        obs_t  e, got;
        int    i = 0;
        int    n, ab_k, ab_mode;
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 6);
            for (int k = 0; k < 8; k++) begin
                dly[k] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
                run_len[k] = $urandom_range(1, 6);
            end
            ab_mode = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            ab_k = (n > 0) ? $urandom_range(0, n - 1) : -1;
            gen_delay(n, ab_k, ab_mode, 1);
            repeat ($urandom_range(0, 2)) begin
                s = idle_s();
                s.abort = 1'($urandom_range(0, 1));
                s.twosec = 1'($urandom_range(0, 1));
                s.rstok = 1'($urandom_range(0, 1));
                push(s, o_idle(m_rem));
            end
        end
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            drive_step(s);
            got = sample();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL random step %0d got %b exp %b", i, got, e);
            end
            i++;
        end
    endtask

    initial begin
        i_ResetN  = 1'b0;
        i_Start   = 1'b0;
        i_Periods = 4'd0;
        i_Abort   = 1'b0;
        i_TwoSec  = 1'b0;
        i_RstOK   = 1'b0;
        test_reset();
        test_two_periods();
        test_zero();
        test_timeout();
        test_abort();
        test_start_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
